// File: rtl/moment_calc.sv
`timescale 1ns/1ps
// D2Q9 moment sweep: per node, read 9 populations, accumulate rho/mx/my, serially divide, write p/ux/uy; 59 cycles/node at default.
// No backpressure (fixed schedule, start sampled only in IDLE). MOMENT_SAT_EN: saturate quotient magnitude instead of wrapping.
module moment_calc #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int GRID_DIM   = 256,
  parameter int NODE_AW    = $clog2(GRID_DIM),
  parameter int FIN_AW     = $clog2(GRID_DIM*9)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [FIN_AW-1:0]     fin_addr,
  input  logic [DATA_WIDTH-1:0] fin_rdata,
  output logic [NODE_AW-1:0]    node_addr,
  output logic [DATA_WIDTH-1:0] p_wdata,
  output logic [DATA_WIDTH-1:0] ux_wdata,
  output logic [DATA_WIDTH-1:0] uy_wdata,
  output logic                  WE_p_mem,
  output logic                  WE_ux_mem,
  output logic                  WE_uy_mem
);

  localparam int QW = DATA_WIDTH + FRAC_BITS;
  localparam int CW = ($clog2(QW) < 4) ? 4 : $clog2(QW);
`ifdef MOMENT_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DIVIDE, S_WRITE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NODE_AW-1:0]    node_q, node_d;
  logic [DATA_WIDTH-1:0] rho_q, rho_d, mx_q, mx_d, my_q, my_d;
  logic [QW-1:0]         dx_q, dx_d, dy_q, dy_d;
  logic [DATA_WIDTH:0]   rx_q, rx_d, ry_q, ry_d;
  logic                  div_zero_q, div_zero_d;
  logic [FIN_AW-1:0]     fin_addr_q, fin_addr_d;
  logic [FIN_AW-1:0]     node_base;
  logic [DATA_WIDTH-1:0] den, qx_mag, qy_mag;
  logic [3:0]            cidx;
  logic                  rho_zero, neg_x, neg_y;

  function automatic logic [DATA_WIDTH-1:0] abs_f(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? -v : v;
  endfunction

  // One restoring step: returns {remainder, dividend/quotient shift register}.
  function automatic logic [QW+DATA_WIDTH:0] div_step(input logic [QW-1:0] dq,
                                                      input logic [DATA_WIDTH:0] r,
                                                      input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH+1:0] rs;
    logic [DATA_WIDTH:0]   diff;
    logic                  ge;
    rs   = {r, dq[QW-1]};
    ge   = (rs >= {2'b00, d});
    diff = rs[DATA_WIDTH:0] - {1'b0, d};
    return {(ge ? diff : rs[DATA_WIDTH:0]), dq[QW-2:0], ge};
  endfunction

  assign node_base = FIN_AW'(node_q) * FIN_AW'(9);
  assign den       = abs_f(rho_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    node_d     = node_q;
    rho_d      = rho_q;
    mx_d       = mx_q;
    my_d       = my_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    div_zero_d = div_zero_q;
    fin_addr_d = fin_addr_q;
    cidx       = cnt_q[3:0];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_READ;
          cnt_d      = '0;
          node_d     = '0;
          rho_d      = '0;
          mx_d       = '0;
          my_d       = '0;
          div_zero_d = 1'b0;
        end
      end
      S_READ: begin
        if (cnt_q < CW'(9)) fin_addr_d = node_base + FIN_AW'(cnt_q);
        // Read data lags the address by one cycle, so cnt k carries population k-1.
        if (cnt_q != '0) begin
          rho_d = rho_q + fin_rdata;
          case (cidx)
            4'd2, 4'd6, 4'd9: mx_d = mx_q + fin_rdata;
            4'd4, 4'd7, 4'd8: mx_d = mx_q - fin_rdata;
            default: ;
          endcase
          case (cidx)
            4'd3, 4'd6, 4'd7: my_d = my_q + fin_rdata;
            4'd5, 4'd8, 4'd9: my_d = my_q - fin_rdata;
            default: ;
          endcase
        end
        if (cnt_q == CW'(9)) begin
          state_d = S_DIVIDE;
          cnt_d   = '0;
          dx_d    = {abs_f(mx_d), {FRAC_BITS{1'b0}}};
          dy_d    = {abs_f(my_d), {FRAC_BITS{1'b0}}};
          rx_d    = '0;
          ry_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIVIDE: begin
        {rx_d, dx_d} = div_step(dx_q, rx_q, den);
        {ry_d, dy_d} = div_step(dy_q, ry_q, den);
        if (cnt_q == CW'(QW-1)) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (rho_zero) div_zero_d = 1'b1;
        if (node_q == NODE_AW'(GRID_DIM-1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          node_d  = node_q + NODE_AW'(1);
          cnt_d   = '0;
          rho_d   = '0;
          mx_d    = '0;
          my_d    = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      node_q     <= '0;
      rho_q      <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      div_zero_q <= 1'b0;
      fin_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      node_q     <= node_d;
      rho_q      <= rho_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      div_zero_q <= div_zero_d;
      fin_addr_q <= fin_addr_d;
    end
  end

  // Quotient magnitude is formed unsigned; sign is restored last so truncation is toward zero.
  always_comb begin
    qx_mag = dx_q[DATA_WIDTH-1:0];
    qy_mag = dy_q[DATA_WIDTH-1:0];
`ifdef MOMENT_SAT_EN
    if (|dx_q[QW-1:DATA_WIDTH-1]) qx_mag = SAT_MAX;
    if (|dy_q[QW-1:DATA_WIDTH-1]) qy_mag = SAT_MAX;
`endif
  end

  assign rho_zero  = (rho_q == '0);
  assign neg_x     = mx_q[DATA_WIDTH-1] ^ rho_q[DATA_WIDTH-1];
  assign neg_y     = my_q[DATA_WIDTH-1] ^ rho_q[DATA_WIDTH-1];
  assign ux_wdata  = rho_zero ? '0 : (neg_x ? -qx_mag : qx_mag);
  assign uy_wdata  = rho_zero ? '0 : (neg_y ? -qy_mag : qy_mag);
  assign p_wdata   = rho_q;
  assign node_addr = node_q;
  assign fin_addr  = fin_addr_d;
  assign busy      = (state_q == S_READ) || (state_q == S_DIVIDE) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign div_zero  = div_zero_q;
  assign WE_p_mem  = (state_q == S_WRITE);
  assign WE_ux_mem = (state_q == S_WRITE);
  assign WE_uy_mem = (state_q == S_WRITE);

endmodule

// File: doc/moment_calc.md
Name: moment_calc

Overview:
- Downstream consumer of the LBM controller's CALC_MOMENT phase.
- Sweeps every lattice node and reads the 9 D2Q9 populations for that node from fin memory.
- Accumulates density and momentum, then divides momentum by density to get velocity.
- Writes density to p memory, x-velocity to ux memory and y-velocity to uy memory, then pulses done so the controller can advance.

Parameters:
- DATA_WIDTH, 32: width of fin/p/ux/uy words, signed two's complement fixed point.
- FRAC_BITS, 16: fractional bits of the fixed-point format (Q15.16 by default).
- GRID_DIM, 256: number of lattice nodes (16*16).
- NODE_AW, $clog2(GRID_DIM): node address width.
- FIN_AW, $clog2(GRID_DIM*9): fin address width.

Ports:
- Clk, input, 1: system clock, rising edge.
- Reset, input, 1: asynchronous active-low reset.
- start, input, 1: begin a full-grid sweep; sampled only in IDLE.
- busy, output, 1: high while a sweep is in progress.
- done, output, 1: one-cycle pulse when the sweep completes.
- div_zero, output, 1: sticky; set when any node had rho==0; cleared by start.
- fin_addr, output, FIN_AW: fin read address, node*9+i.
- fin_rdata, input, DATA_WIDTH: fin read data, valid 1 cycle after fin_addr.
- node_addr, output, NODE_AW: write address for the p/ux/uy memories.
- p_wdata, output, DATA_WIDTH: density rho.
- ux_wdata, output, DATA_WIDTH: x-velocity.
- uy_wdata, output, DATA_WIDTH: y-velocity.
- WE_p_mem, output, 1: p memory write enable.
- WE_ux_mem, output, 1: ux memory write enable.
- WE_uy_mem, output, 1: uy memory write enable.

Behaviour:
- Reset (asynchronous, Reset=0):
  - State=IDLE.
  - All outputs 0, including busy, done, div_zero, addresses, wdata and WE.
  - Accumulators and node counter cleared.
- Direction vectors (cx,cy) by index i:
  - 0:(0,0), 1:(1,0), 2:(0,1), 3:(-1,0), 4:(0,-1)
  - 5:(1,1), 6:(-1,1), 7:(-1,-1), 8:(1,-1)
- State machine: IDLE, READ, DIVIDE, WRITE, DONE.
- IDLE:
  - On start=1: clear div_zero, set node=0, go to READ.
  - busy rises the next cycle.
- READ, 10 cycles:
  - Cycles 0..8: fin_addr = node*9 + i.
  - Cycles 1..9: accumulate fin_rdata for i-1.
  - rho += f; mx += cx*f; my += cy*f.
  - Accumulation is DATA_WIDTH wide and wraps two's complement.
  - Then go to DIVIDE.
- DIVIDE, DATA_WIDTH+FRAC_BITS cycles (48 at default):
  - Two parallel serial restoring dividers compute (|mx|<<FRAC_BITS)/|rho| and (|my|<<FRAC_BITS)/|rho|.
  - Sign is applied afterwards; result truncates toward zero.
  - If rho==0: quotients are forced to 0 and div_zero is set.
- WRITE, 1 cycle:
  - node_addr=node, p_wdata=rho, ux_wdata and uy_wdata = the quotients.
  - WE_p_mem, WE_ux_mem and WE_uy_mem are all 1 in this cycle only.
  - If node==GRID_DIM-1 go to DONE; otherwise node++, clear the accumulators, go to READ.
- DONE, 1 cycle: done=1, busy=0, then back to IDLE.
- Latency: 59 cycles per node at default parameters. done is asserted GRID_DIM*59+1 cycles after the start-sampling cycle.
- start while busy: ignored; no restart and no state change.
- Reset mid-sweep: immediate return to IDLE. Partially written memories are left as-is; the new sweep needs a fresh start.
- fin_addr holds its last value outside READ. WE strobes are never asserted outside WRITE.

Optional Feature:
- Macro: MOMENT_SAT_EN.
- Defined: the full-width quotient saturates to the signed DATA_WIDTH range before the sign is applied.
  - Positive results clamp to 0x7FFF_FFFF.
  - Negative results clamp to 0x8000_0001.
- Undefined: only the low DATA_WIDTH bits of the quotient are kept (wrap), and no saturation logic is built.

Test Plan:
- Uniform node, all f_i=0x0001_0000 -> p=0x0009_0000, ux=0, uy=0, div_zero=0.
- f0=0x0002_0000, f1=0x0002_0000, others 0 -> p=0x0004_0000, ux=0x0000_8000, uy=0.
- f7=0x0001_0000 only -> p=0x0001_0000, ux=0xFFFF_0000, uy=0xFFFF_0000.
- All f=0 at node 3 -> p=0, ux=uy=0, div_zero=1 held through done; next start clears it.
- f1=0x4000_0000, f0=0xC000_0001 (rho=1 LSB):
  - With MOMENT_SAT_EN: ux=0x7FFF_FFFF.
  - Without it: ux=0x0000_0000.
- GRID_DIM=4 sweep:
  - done at cycle 237 after start; exactly 4 write strobes at node_addr 0..3.
  - start pulsed mid-sweep is ignored.
  - Reset asserted in DIVIDE drops busy to 0 immediately; a fresh start then reproduces the correct results.
